// File: rtl/muldiv_pkg.sv
// Shared definitions for the sequential MIPS multiply/divide controller:
// op encodings, FSM state encoding and the shared ALU add/sub opsel codes.
package muldiv_pkg;

  localparam int MD_W        = 32;
  localparam int ALU_OPSEL_W = 4;

  // Opsel codes as decoded by the core's shared ALU
  localparam logic [ALU_OPSEL_W-1:0] ALU_ADDU = 4'b0010;
  localparam logic [ALU_OPSEL_W-1:0] ALU_SUBU = 4'b0110;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [2:0] {
    MD_IDLE   = 3'd0,
    MD_NEG_A  = 3'd1,
    MD_NEG_B  = 3'd2,
    MD_ITER   = 3'd3,
    MD_FIX_LO = 3'd4,
    MD_FIX_HI = 3'd5,
    MD_DONE   = 3'd6
  } md_state_e;

endpackage

// File: rtl/muldiv_fsm.sv
// Sequencer for muldiv_seq: state register, iteration counter and busy/done.
// The state is exported so the top (and any bound checker) can decode it.
module muldiv_fsm
  import muldiv_pkg::*;
#(
  parameter int W = MD_W
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      start,
  output md_state_e state,
  output logic      busy,
  output logic      done,
  output logic      accept
);

  localparam int CNT_W = $clog2(W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

  md_state_e        state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= MD_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      MD_IDLE:   if (start) state_nxt = MD_NEG_A;
      MD_NEG_A:  state_nxt = MD_NEG_B;
      MD_NEG_B: begin
        state_nxt = MD_ITER;
        cnt_nxt   = '0;
      end
      MD_ITER: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == CNT_LAST) state_nxt = MD_FIX_LO;
      end
      MD_FIX_LO: state_nxt = MD_FIX_HI;
      MD_FIX_HI: state_nxt = MD_DONE;
      MD_DONE:   state_nxt = MD_IDLE;
      default:   state_nxt = MD_IDLE;
    endcase
  end

  // Handshake: start is taken only in IDLE (accept); busy covers every cycle
  // after that up to, not including, the single done cycle.
  assign accept = (state == MD_IDLE) && start;
  assign busy   = (state != MD_IDLE) && (state != MD_DONE);
  assign done   = (state == MD_DONE);

endmodule

// File: rtl/muldiv_seq.sv
// MULT/MULTU/DIV/DIVU controller that time-shares the core ALU, one add/sub per
// cycle. Define MULDIV_DIV0_FLAG_EN to add the div0 divide-by-zero flag output.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int W       = MD_W,
  parameter int OPSEL_W = ALU_OPSEL_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [W-1:0]       rs,
  input  logic [W-1:0]       rt,
  output logic               busy,
  output logic               done,
  output logic [W-1:0]       hi,
  output logic [W-1:0]       lo,
`ifdef MULDIV_DIV0_FLAG_EN
  output logic               div0,
`endif
  output logic [W-1:0]       alu_op_a,
  output logic [W-1:0]       alu_op_b,
  output logic [OPSEL_W-1:0] alu_opsel,
  input  logic [W-1:0]       alu_result,
  input  logic               alu_cf
);

  localparam logic [OPSEL_W-1:0] OPSEL_ADD = OPSEL_W'(ALU_ADDU);
  localparam logic [OPSEL_W-1:0] OPSEL_SUB = OPSEL_W'(ALU_SUBU);

  md_state_e    state;
  logic         accept;
  md_op_e       op_q;
  logic [W-1:0] a_q, b_q;
  logic         neg_q, neg_r, lo_zero;
  logic         div_op, sgn_op;
  logic [W-1:0] shifted, b_mag;

  muldiv_fsm #(.W(W)) u_fsm (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .state  (state),
    .busy   (busy),
    .done   (done),
    .accept (accept)
  );

  assign div_op  = (op_q == MD_DIV) || (op_q == MD_DIVU);
  assign sgn_op  = (op_q == MD_MULT) || (op_q == MD_DIV);
  assign shifted = {hi[W-2:0], lo[W-1]};
  assign b_mag   = (sgn_op && b_q[W-1]) ? alu_result : b_q;

  always_comb begin
    alu_op_a  = '0;
    alu_op_b  = '0;
    alu_opsel = OPSEL_ADD;
    case (state)
      MD_NEG_A: begin
        alu_opsel = OPSEL_SUB;
        alu_op_b  = a_q;
      end
      MD_NEG_B: begin
        alu_opsel = OPSEL_SUB;
        alu_op_b  = b_q;
      end
      MD_ITER: begin
        if (div_op) begin
          alu_opsel = OPSEL_SUB;
          alu_op_a  = shifted;
          alu_op_b  = b_q;
        end else begin
          alu_op_a = hi;
          alu_op_b = lo[0] ? a_q : '0;
        end
      end
      MD_FIX_LO: begin
        alu_opsel = OPSEL_SUB;
        alu_op_b  = lo;
      end
      MD_FIX_HI: begin
        if (div_op) begin
          alu_opsel = OPSEL_SUB;
          alu_op_b  = hi;
        end else begin
          // Two's complement of {HI,LO}: carry out of the LO negate is lo_zero
          alu_op_a = ~hi;
          alu_op_b = {{(W-1){1'b0}}, lo_zero};
        end
      end
      default: ;
    endcase
  end

  // a_q holds the multiplicand magnitude; b_q the multiplier/divisor magnitude
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= MD_MULT;
      a_q     <= '0;
      b_q     <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      lo_zero <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      case (state)
        MD_IDLE: if (accept) begin
          op_q  <= md_op_e'(op);
          a_q   <= rs;
          b_q   <= rt;
          neg_q <= ~op[0] & (rs[W-1] ^ rt[W-1]);
          neg_r <= ~op[0] & rs[W-1];
        end
        MD_NEG_A: if (sgn_op && a_q[W-1]) a_q <= alu_result;
        MD_NEG_B: begin
          b_q <= b_mag;
          hi  <= '0;
          lo  <= div_op ? a_q : b_mag;
        end
        MD_ITER: begin
          if (div_op) begin
            if (hi[W-1] | alu_cf) begin
              hi <= alu_result;
              lo <= {lo[W-2:0], 1'b1};
            end else begin
              hi <= shifted;
              lo <= {lo[W-2:0], 1'b0};
            end
          end else begin
            hi <= {alu_cf, alu_result[W-1:1]};
            lo <= {alu_result[0], lo[W-1:1]};
          end
        end
        MD_FIX_LO: begin
          if (neg_q) lo <= alu_result;
          lo_zero <= (lo == '0);
        end
        MD_FIX_HI: if (div_op ? neg_r : neg_q) hi <= alu_result;
        default: ;
      endcase
    end
  end

`ifdef MULDIV_DIV0_FLAG_EN
  // A zero divisor stays zero through negation, so b_q still identifies it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div0 <= 1'b0;
    end else if (accept) begin
      div0 <= 1'b0;
    end else if (state == MD_FIX_HI) begin
      div0 <= div_op && (b_q == '0);
    end
  end
`endif

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq with a behavioural model of the shared ALU.
// Build with +define+MULDIV_DIV0_FLAG_EN to also check the div0 flag.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  localparam int W       = 32;
  localparam int OPSEL_W = 4;
  localparam int LAT     = W + 5;

  logic               clk   = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic [1:0]         op    = 2'b00;
  logic [W-1:0]       rs    = '0;
  logic [W-1:0]       rt    = '0;
  logic               busy, done;
  logic [W-1:0]       hi, lo;
  logic [W-1:0]       alu_op_a, alu_op_b, alu_result;
  logic [OPSEL_W-1:0] alu_opsel;
  logic               alu_cf;
`ifdef MULDIV_DIV0_FLAG_EN
  logic               div0;
`endif

  logic [2*W-1:0] exp_q[$];
  int             n_vec = 0;
  int             n_err = 0;

  muldiv_seq #(.W(W), .OPSEL_W(OPSEL_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .op         (op),
    .rs         (rs),
    .rt         (rt),
    .busy       (busy),
    .done       (done),
    .hi         (hi),
    .lo         (lo),
`ifdef MULDIV_DIV0_FLAG_EN
    .div0       (div0),
`endif
    .alu_op_a   (alu_op_a),
    .alu_op_b   (alu_op_b),
    .alu_opsel  (alu_opsel),
    .alu_result (alu_result),
    .alu_cf     (alu_cf)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- shared ALU model ----------------
  logic [W:0] alu_sum;
  always_comb begin
    alu_sum = '0;
    if (alu_opsel == ALU_ADDU)
      alu_sum = {1'b0, alu_op_a} + {1'b0, alu_op_b};
    else if (alu_opsel == ALU_SUBU)
      alu_sum = {1'b0, alu_op_a} + {1'b0, ~alu_op_b} + (W+1)'(1);
  end
  assign alu_result = alu_sum[W-1:0];
  assign alu_cf     = alu_sum[W];

  // ---------------- reference model ----------------
  function automatic logic [2*W-1:0] model_md(input logic [1:0] o,
                                              input logic [W-1:0] a,
                                              input logic [W-1:0] b);
    longint sa, sb, q, r;
    logic [2*W-1:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = '0;
    case (o)
      2'b00: p = sa * sb;
      2'b01: p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      2'b10: begin
        if (b == '0) begin
          p = {a, (a[W-1] ? W'(1) : {W{1'b1}})};
        end else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[W-1:0], q[W-1:0]};
        end
      end
      default: begin
        if (b == '0) p = {a, {W{1'b1}}};
        else         p = {a % b, a / b};
      end
    endcase
    return p;
  endfunction

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // ---------------- driver + scoreboard ----------------
  // Issues one op, optionally re-pulses start at cycle poke_at while busy,
  // and checks the result when done appears (cycle 1 = first cycle after start).
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] exp, input int poke_at);
    int dones   = 0;
    int done_at = 0;
    logic [2*W-1:0] e;
    exp_q.push_back(exp);
    @(negedge clk);
    start = 1'b1; op = o; rs = a; rt = b;
    @(negedge clk);
    start = 1'b0; op = 2'($urandom_range(0, 3)); rs = $urandom; rt = $urandom;
    for (int n = 1; n <= LAT + 8; n++) begin
      if (n == 1)       chk("busy_first", 64'(busy), 64'(1));
      if (n == LAT - 1) chk("busy_last", 64'(busy), 64'(1));
      if (done) begin
        dones++;
        done_at = n;
        chk("busy_at_done", 64'(busy), 64'(0));
        chk("alu_ops_idle", {alu_op_a, alu_op_b}, 64'(0));
        chk("alu_opsel_idle", 64'(alu_opsel), 64'(ALU_ADDU));
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("hi", 64'(hi), 64'(e[2*W-1:W]));
          chk("lo", 64'(lo), 64'(e[W-1:0]));
        end
`ifdef MULDIV_DIV0_FLAG_EN
        chk("div0", 64'(div0), 64'(o[1] && (b == '0)));
`endif
      end
      start = (n == poke_at);
      if (n == poke_at) begin
        op = 2'($urandom_range(0, 3)); rs = $urandom; rt = $urandom;
      end
      @(negedge clk);
    end
    chk("done_count", 64'(dones), 64'(1));
    chk("latency", 64'(done_at), 64'(LAT));
    chk("hold_hilo", {hi, lo}, exp);
    if (exp_q.size() > 0) exp_q.delete();
  endtask

  logic [1:0]   r_op;
  logic [W-1:0] r_a, r_b;
  int           abort_dones;

  initial begin
    // ---------------- reset ----------------
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_hilo", {hi, lo}, 64'(0));
    chk("rst_alu_ops", {alu_op_a, alu_op_b}, 64'(0));
    chk("rst_alu_opsel", 64'(alu_opsel), 64'(ALU_ADDU));
`ifdef MULDIV_DIV0_FLAG_EN
    chk("rst_div0", 64'(div0), 64'(0));
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // ---------------- directed vectors ----------------
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001}, 0);
    run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, {32'hFFFF_FFFF, 32'hFFFF_FFEB}, 0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 0);
    run_op(2'b11, 32'd100,       32'd0,         {32'h0000_0064, 32'hFFFF_FFFF}, 0);
    run_op(2'b01, 32'd5,         32'd6,         {32'h0000_0000, 32'h0000_001E}, 10);
    run_op(2'b00, 32'hFFFF_FFFC, 32'd0,         {32'h0000_0000, 32'h0000_0000}, 0);
    run_op(2'b00, 32'hFFFF_0000, 32'h0001_0000, {32'hFFFF_FFFF, 32'h0000_0000}, 0);
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, {32'h4000_0000, 32'h0000_0000}, 0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000}, 0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd0,         {32'hFFFF_FFF9, 32'h0000_0001}, 0);
    run_op(2'b11, 32'hFFFF_FFFF, 32'h8000_0001, {32'h7FFF_FFFE, 32'h0000_0001}, 0);

    // ---------------- reset mid-operation ----------------
    @(negedge clk);
    start = 1'b1; op = 2'b11; rs = 32'd1000; rt = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_done", 64'(done), 64'(0));
    chk("abort_hilo", {hi, lo}, 64'(0));
    chk("abort_alu_ops", {alu_op_a, alu_op_b}, 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    abort_dones = 0;
    for (int n = 0; n < LAT + 5; n++) begin
      if (done) abort_dones++;
      @(negedge clk);
    end
    chk("abort_no_done", 64'(abort_dones), 64'(0));
    run_op(2'b11, 32'd1000, 32'd7, {32'd6, 32'd142}, 0);

    // ---------------- random vectors ----------------
    for (int i = 0; i < 12; i++) begin
      r_op = 2'($urandom_range(0, 3));
      r_a  = (i % 4 == 1) ? W'($urandom_range(0, 255)) : $urandom;
      r_b  = (i % 3 == 0) ? W'($urandom_range(0, 15)) : $urandom;
      run_op(r_op, r_a, r_b, model_md(r_op, r_a, r_b), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
